inst_encoder_loader: RTL

// - Encodes field-level instruction descriptors (class, fn, rd, rs1, rs2, imm) into 32-bit ISA words.
// - Streams the words into instruction memory through a write port.
// - It is the inverse of the pipeline's instruction decoder, used by the boot/debug path to load programs.
// - Descriptors enter on a valid/ready handshake and are buffered in a small FIFO.
// - A sequential address counter places the words starting at a programmable base.

---
 rtl/inst_encoder_loader_pkg.sv | 39 +++
 rtl/inst_encoder_loader_fifo.sv | 52 +++++
 rtl/inst_encoder_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/inst_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: class codes, NOP word,
// controller state encodings and the field-level descriptor layout.
package inst_encoder_loader_pkg;

  localparam logic [3:0] CLS_ALU  = 4'b0000;
  localparam logic [3:0] CLS_CMP  = 4'b0010;
  localparam logic [3:0] CLS_SW   = 4'b0101;
  localparam logic [3:0] CLS_BR   = 4'b0110;
  localparam logic [3:0] CLS_ALUI = 4'b1000;
  localparam logic [3:0] CLS_LW   = 4'b1001;
  localparam logic [3:0] CLS_CMPI = 4'b1010;
  localparam logic [3:0] CLS_JAL  = 4'b1011;
  localparam logic [3:0] CLS_NOP  = 4'b1111;

  localparam logic [31:0] NOP_WORD = 32'hF000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  fn;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } desc_t;

  function automatic logic cls_known(input logic [3:0] c);
    case (c)
      CLS_ALU, CLS_CMP, CLS_ALUI, CLS_CMPI, CLS_LW,
      CLS_JAL, CLS_BR, CLS_SW, CLS_NOP: cls_known = 1'b1;
      default:                          cls_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_loader_fifo.sv
// Synchronous word FIFO with flush; head is visible combinationally on o_rdata.
module inst_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_one
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  // A pop frees the head slot this cycle, so a push is legal even when full.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_one   = (r_cnt == (AW+1)'(1));
  assign o_rdata = r_mem[r_rp];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Encodes instruction descriptors into 32-bit ISA words and streams them into
// instruction memory at sequential addresses starting from a programmable base.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_finish,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_in_class,
  input  logic [3:0]        i_in_fn,
  input  logic [3:0]        i_in_rd,
  input  logic [3:0]        i_in_rs1,
  input  logic [3:0]        i_in_rs2,
  input  logic [15:0]       i_in_imm,
  output logic              o_mem_wr_en,
  input  logic              i_mem_wr_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wr_data,
  output logic              o_done,
  output logic              o_err_illegal,
  output logic              o_wrapped
);

  function automatic logic [31:0] encode(input desc_t d);
    case (d.cls)
      CLS_ALU, CLS_CMP:                    encode = {d.cls, d.fn, d.rd, d.rs1, d.rs2, 12'h000};
      CLS_ALUI, CLS_CMPI, CLS_LW, CLS_JAL: encode = {d.cls, d.fn, d.rd, d.rs1, d.imm};
      CLS_BR, CLS_SW:                      encode = {d.cls, d.fn, d.rs1, d.rs2, d.imm};
      default:                             encode = NOP_WORD;
    endcase
  endfunction

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err, r_wrap;
  desc_t             w_desc;
  logic [31:0]       w_head;
  logic              w_full, w_empty, w_one, w_accept, w_wr_en, w_pop;

  assign w_desc   = {i_in_class, i_in_fn, i_in_rd, i_in_rs1, i_in_rs2, i_in_imm};
  assign w_accept = i_in_valid & o_in_ready;
  assign w_wr_en  = ((r_state == ST_RUN) | (r_state == ST_DRAIN)) & ~w_empty;
  assign w_pop    = w_wr_en & i_mem_wr_ready;

  inst_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_flush (i_start),
    .i_push  (w_accept),
    .i_wdata (encode(w_desc)),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_one   (w_one)
  );

  assign o_in_ready    = (r_state == ST_RUN) & ~w_full;
  assign o_mem_wr_en   = w_wr_en;
  assign o_mem_addr    = r_addr;
  assign o_mem_wr_data = w_wr_en ? w_head : 32'h0;
  assign o_done        = (r_state == ST_DONE);
  assign o_err_illegal = r_err;
  assign o_wrapped     = r_wrap;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_start) begin
      r_state <= ST_RUN;
      r_addr  <= i_base_addr;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (&r_addr) r_wrap <= 1'b1;
      end
      if (w_accept && !cls_known(i_in_class)) r_err <= 1'b1;
      // Leave DRAIN on the edge that retires the last word so done follows it directly.
      case (r_state)
        ST_RUN:   if (i_finish) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty || (w_pop && w_one)) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
